jtag_host_engine: RTL

- JTAG host (initiator) that drives a target TAP controller's TCK/TMS/TDI pins and samples its TDO.
- Accepts IR-scan, DR-scan and reset commands over a valid/ready interface and generates the TMS walk and divided test clock.
- Returns captured TDO bits over a valid/ready response interface.
- Sits between a debug or command bus and the off-chip or on-chip TAP port.

---
 rtl/jtag_host_engine.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/jtag_host_engine.sv
// JTAG host: turns DR/IR-scan and TAP-reset commands into TCK/TMS/TDI pin sequences
// and returns the captured TDO bits as a response.
//
// state   | meaning
// RST_SEQ | 5 periods TMS=1 then 1 period TMS=0, target ends in Run-Test/Idle
// IDLE    | ready for a command, target parked in Run-Test/Idle
// HDR     | TMS walk from Run-Test/Idle to Shift-DR / Shift-IR
// SHIFT   | LEN periods of TDI out / TDO in, last one exits to Exit1
// TAIL    | Update then back to Run-Test/Idle
// RESP    | response held until RSP_READY
module jtag_host_engine #(
    parameter int MAX_LEN = 32,
    parameter int DIV     = 2,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               TCK,
    input  logic               TRST,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [1:0]         CMD_OP,
    input  logic [LEN_W-1:0]   CMD_LEN,
    input  logic [MAX_LEN-1:0] CMD_DATA,
    output logic               RSP_VALID,
    input  logic               RSP_READY,
    output logic [MAX_LEN-1:0] RSP_DATA,
    output logic               RSP_ERR,
    output logic               TCK_O,
    output logic               TMS_O,
    output logic               TDI_O,
    input  logic               TDO_I,
    output logic               BUSY
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;

    typedef enum logic [2:0] {RST_SEQ, IDLE, HDR, SHIFT, TAIL, RESP} state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   per_cnt, per_nxt;
    logic [LEN_W-1:0]   len_q;
    logic               op_ir, ir_nxt;
    logic [MAX_LEN-1:0] sh_q, rsp_q;
    logic               tck_q, tms_q, tdi_q, err_q;
    logic               busy, div_tc, tck_rise, tck_fall;
    logic               per_last, cmd_acc, cmd_bad, tms_nxt;

    assign busy     = (state == RST_SEQ) || (state == HDR) || (state == SHIFT) || (state == TAIL);
    assign div_tc   = (div_cnt == DIV_W'(DIV - 1));
    assign tck_rise = busy && div_tc && !tck_q;
    assign tck_fall = busy && div_tc && tck_q;
    assign cmd_acc  = (state == IDLE) && CMD_VALID;
    assign cmd_bad  = (CMD_OP == 2'b11) || (CMD_LEN == '0) || (CMD_LEN > LEN_W'(MAX_LEN));
    assign ir_nxt   = cmd_acc ? CMD_OP[0] : op_ir;

    always_comb begin
        per_last = 1'b0;
        case (state)
            RST_SEQ: per_last = (per_cnt == CNT_W'(5));
            HDR:     per_last = (per_cnt == (op_ir ? CNT_W'(3) : CNT_W'(2)));
            SHIFT:   per_last = (per_cnt == CNT_W'(len_q) - CNT_W'(1));
            TAIL:    per_last = (per_cnt == CNT_W'(1));
            default: per_last = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_acc) begin
                    if (cmd_bad)                state_nxt = RESP;
                    else if (CMD_OP == 2'b10)   state_nxt = RST_SEQ;
                    else                        state_nxt = HDR;
                end
            end
            RST_SEQ: if (tck_fall && per_last) state_nxt = IDLE;
            HDR:     if (tck_fall && per_last) state_nxt = SHIFT;
            SHIFT:   if (tck_fall && per_last) state_nxt = TAIL;
            TAIL:    if (tck_fall && per_last) state_nxt = RESP;
            RESP:    if (RSP_READY)            state_nxt = IDLE;
            default: state_nxt = RST_SEQ;
        endcase
    end

    // period index and TMS level for the period that starts on this edge
    always_comb begin
        per_nxt = per_cnt;
        if (cmd_acc || (tck_fall && per_last))
            per_nxt = '0;
        else if (tck_fall)
            per_nxt = per_cnt + CNT_W'(1);
        tms_nxt = 1'b0;
        case (state_nxt)
            RST_SEQ: tms_nxt = (per_nxt < CNT_W'(5));
            HDR:     tms_nxt = (per_nxt == '0) || (ir_nxt && (per_nxt == CNT_W'(1)));
            SHIFT:   tms_nxt = (per_nxt == CNT_W'(len_q) - CNT_W'(1));
            TAIL:    tms_nxt = (per_nxt == '0);
            default: tms_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) state <= RST_SEQ;
        else       state <= state_nxt;
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            div_cnt <= '0;
            per_cnt <= '0;
            len_q   <= '0;
            op_ir   <= 1'b0;
            sh_q    <= '0;
            rsp_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (busy) begin
                div_cnt <= div_tc ? '0 : div_cnt + DIV_W'(1);
                if (div_tc) tck_q <= !tck_q;
            end
            per_cnt <= per_nxt;
            if (cmd_acc || tck_fall) tms_q <= tms_nxt;
            // TDO enters at the top; the final shift right-aligns bit 0 to the first sample
            if (tck_rise && (state == SHIFT)) rsp_q <= {TDO_I, rsp_q[MAX_LEN-1:1]};
            if (tck_fall) begin
                if (state_nxt == SHIFT) begin
                    tdi_q <= sh_q[0];
                    sh_q  <= sh_q >> 1;
                end else begin
                    tdi_q <= 1'b0;
                end
                if ((state == SHIFT) && per_last)
                    rsp_q <= rsp_q >> (LEN_W'(MAX_LEN) - len_q);
            end
            if (cmd_acc) begin
                div_cnt <= '0;
                rsp_q   <= '0;
                err_q   <= cmd_bad;
                len_q   <= CMD_LEN;
                op_ir   <= CMD_OP[0];
                sh_q    <= CMD_DATA;
            end
            if ((state == RESP) && RSP_READY) err_q <= 1'b0;
        end
    end

    assign CMD_READY = (state == IDLE);
    assign RSP_VALID = (state == RESP);
    assign RSP_DATA  = rsp_q;
    assign RSP_ERR   = err_q;
    assign BUSY      = busy;
    assign TCK_O     = tck_q;
    assign TMS_O     = tms_q;
    assign TDI_O     = tdi_q;

endmodule
